// File: rtl/conv_taps_gen_pkg.sv
// Shared constants, FSM encoding and layer-select encoding for the conv_taps_gen window generator.
package conv_pkg;

    localparam int K      = 5;
    localparam int DW     = 32;
    localparam int NI_L1  = 28;
    localparam int NI_L2  = 12;
    localparam int NI_MAX = 28;
    localparam int CW     = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_t;

    typedef enum logic {
        LAYER_1 = 1'b0,
        LAYER_2 = 1'b1
    } layer_t;

    function automatic logic [CW-1:0] ni_of(input layer_t layer);
        return (layer == LAYER_2) ? CW'(NI_L2) : CW'(NI_L1);
    endfunction

endpackage

// File: rtl/conv_taps_gen_lb_line.sv
// One line buffer: NI_MAX-deep shift line with a run-time selectable read tap at index ni-1.
module lb_line #(
    parameter int DW     = 32,
    parameter int NI_MAX = 28
) (
    input  logic                          clk,
    input  logic                          en,
    input  logic [DW-1:0]                 din,
    input  logic [$clog2(NI_MAX+1)-1:0]   ni,
    output logic [DW-1:0]                 dout
);

    // storage is intentionally unreset; qualification downstream hides stale contents
    logic [DW-1:0] sr [NI_MAX];

    always_ff @(posedge clk) begin
        if (en) begin
            sr[0] <= din;
            for (int i = 1; i < NI_MAX; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    always_comb begin
        dout = sr[NI_MAX-1];
        for (int i = 0; i < NI_MAX; i++) begin
            if (int'(ni) == i + 1) begin
                dout = sr[i];
            end
        end
    end

endmodule

// File: rtl/conv_taps_gen.sv
// Line-buffer column generator feeding the 5x5 binary convolution engine.
// Optional stall counter output enabled by defining CONV_TAPS_STALL_CNT_EN.
//
//   state | meaning
//   IDLE  | waiting for start; din_ready low
//   RUN   | accepting raster pixels until the last pixel of the frame
//   DONE  | one-cycle frame_done pulse, then back to IDLE
module conv_taps_gen
    import conv_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              state,
    input  logic [DW-1:0]     din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic [K*DW-1:0]   taps,
    output logic              taps_valid,
    output logic              win_valid,
    output logic              busy,
    output logic              frame_done
`ifdef CONV_TAPS_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    fsm_t            fsm_q;
    fsm_t            fsm_d;
    layer_t          layer_q;
    logic [CW-1:0]   row_q;
    logic [CW-1:0]   col_q;
    logic [CW-1:0]   ni;
    logic            accept;
    logic            last_col;
    logic            last_px;
    logic [DW-1:0]   chain [K];
    logic [K*DW-1:0] taps_d;

    assign ni       = ni_of(layer_q);
    assign accept   = din_valid && din_ready;
    assign last_col = (col_q == ni - CW'(1));
    assign last_px  = last_col && (row_q == ni - CW'(1));

    // chain[0] is the live pixel, chain[j+1] is chain[j] delayed by one row
    assign chain[0] = din;

    for (genvar j = 0; j < K - 1; j++) begin : g_lb
        lb_line #(
            .DW     (DW),
            .NI_MAX (NI_MAX)
        ) u_lb (
            .clk  (clk),
            .en   (accept),
            .din  (chain[j]),
            .ni   (ni),
            .dout (chain[j+1])
        );
    end

    always_comb begin
        taps_d = '0;
        for (int j = 0; j < K; j++) begin
            taps_d[j*DW +: DW] = chain[j];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q <= IDLE;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            IDLE:    if (start) fsm_d = RUN;
            RUN:     if (accept && last_px) fsm_d = DONE;
            DONE:    fsm_d = IDLE;
            default: fsm_d = IDLE;
        endcase
    end

    always_comb begin
        din_ready  = (fsm_q == RUN);
        busy       = (fsm_q != IDLE);
        frame_done = (fsm_q == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            layer_q    <= LAYER_1;
            row_q      <= '0;
            col_q      <= '0;
            taps       <= '0;
            taps_valid <= 1'b0;
            win_valid  <= 1'b0;
        end else begin
            taps_valid <= 1'b0;
            win_valid  <= 1'b0;
            if (fsm_q == IDLE && start) begin
                layer_q <= layer_t'(state);
                row_q   <= '0;
                col_q   <= '0;
            end
            if (accept) begin
                taps       <= taps_d;
                taps_valid <= (row_q >= CW'(K-1));
                win_valid  <= (row_q >= CW'(K-1)) && (col_q >= CW'(K-1));
                if (last_col) begin
                    col_q <= '0;
                    row_q <= row_q + CW'(1);
                end else begin
                    col_q <= col_q + CW'(1);
                end
            end
        end
    end

`ifdef CONV_TAPS_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (fsm_q == IDLE && start) begin
            stall_cnt <= '0;
        end else if (fsm_q == RUN && !din_valid && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`else
    // without the stall counter there is no extra state to maintain
`endif

endmodule

// File: tb/tb_conv_taps_gen.sv
// Scoreboard bench for conv_taps_gen: a frame-level reference model queues expected columns, a monitor checks them.
module tb_conv_taps_gen;
    import conv_pkg::*;

    localparam int TW = K * DW;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic            state_in = 1'b0;
    logic [DW-1:0]   din = '0;
    logic            din_valid = 1'b0;
    logic            din_ready;
    logic [TW-1:0]   taps;
    logic            taps_valid;
    logic            win_valid;
    logic            busy;
    logic            frame_done;
`ifdef CONV_TAPS_STALL_CNT_EN
    logic [15:0]     stall_cnt;
`endif

    conv_taps_gen dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .state      (state_in),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .taps       (taps),
        .taps_valid (taps_valid),
        .win_valid  (win_valid),
        .busy       (busy),
        .frame_done (frame_done)
`ifdef CONV_TAPS_STALL_CNT_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [TW-1:0] taps;
        bit            win;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          mon_e;
    int            checks = 0;
    int            errors = 0;
    int            tv_cnt = 0;
    int            win_cnt = 0;
    int            fd_cnt = 0;
    bit            got_first = 1'b0;
    logic [TW-1:0] first_taps = '0;
    logic [TW-1:0] last_taps = '0;
    logic [DW-1:0] pix [NI_MAX][NI_MAX];

    task automatic chk(input string name, input logic [TW-1:0] act, input logic [TW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [TW-1:0] col5(input int a, input int b, input int c, input int d, input int e);
        return {DW'(a), DW'(b), DW'(c), DW'(d), DW'(e)};
    endfunction

    always @(negedge clk) begin
        if (frame_done) fd_cnt++;
        checks++;
        if (win_valid && !taps_valid) begin
            errors++;
            $display("FAIL win_without_taps actual=1 required=0");
        end
        if (taps_valid) begin
            tv_cnt++;
            if (win_valid) win_cnt++;
            if (!got_first) begin
                first_taps = taps;
                got_first  = 1'b1;
            end
            last_taps = taps;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_column actual=%0h required=none", taps);
            end else begin
                mon_e = exp_q.pop_front();
                if (taps !== mon_e.taps || win_valid !== mon_e.win) begin
                    errors++;
                    $display("FAIL column actual=%0h/%0b required=%0h/%0b",
                             taps, win_valid, mon_e.taps, mon_e.win);
                end
            end
        end
    end

    task automatic run_frame(input bit layer, input int gap_pct, input bit rand_data,
                             input bit toggle_state, input bit poke_start, input int abort_at);
        int   ni;
        int   idx;
        int   idle;
        int   budget;
        int   fd0;
        bit   v;
        bit   acc;
        bit   aborted;
        exp_t e;

        ni = layer ? NI_L2 : NI_L1;
        for (int r = 0; r < ni; r++)
            for (int c = 0; c < ni; c++)
                pix[r][c] = rand_data ? DW'($urandom) : DW'(r * ni + c);

        // each output column is the vertical strip of K pixels ending at the current row
        for (int r = K - 1; r < ni; r++) begin
            for (int c = 0; c < ni; c++) begin
                for (int k = 0; k < K; k++) e.taps[k*DW +: DW] = pix[r-k][c];
                e.win = (c >= K - 1);
                exp_q.push_back(e);
            end
        end

        tv_cnt = 0; win_cnt = 0; got_first = 1'b0; fd0 = fd_cnt;

        @(posedge clk); #1;
        start = 1'b1; state_in = layer;
        @(posedge clk); #1;
        start = 1'b0;

        idx = 0; idle = 0; budget = 0; aborted = 1'b0;
        while (idx < ni * ni) begin
            if (budget > 4 * ni * ni + 50) begin
                checks++; errors++;
                $display("FAIL frame_timeout actual=%0d required=%0d", idx, ni * ni);
                break;
            end
            budget++;
            v = ($urandom_range(99) >= gap_pct);
            if (idx == abort_at) v = 1'b1;
            din_valid = v;
            din = pix[idx / ni][idx % ni];
            if (toggle_state) state_in = 1'($urandom_range(1));
            if (poke_start) start = ($urandom_range(9) == 0);
            if (!v) idle++;
            if (idx == abort_at) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                aborted = 1'b1;
                break;
            end
            acc = v && din_ready;
            @(posedge clk); #1;
            if (acc) idx++;
        end
        din_valid = 1'b0;
        start = 1'b0;

        if (aborted) begin
            chk("abort_taps", taps, '0);
            chk("abort_taps_valid", TW'(taps_valid), '0);
            chk("abort_win_valid", TW'(win_valid), '0);
            chk("abort_busy", TW'(busy), '0);
            chk("abort_din_ready", TW'(din_ready), '0);
            chk("abort_frame_done", TW'(frame_done), '0);
            exp_q.delete();
            repeat (5) @(posedge clk);
            #1;
            chk("abort_no_frame_done", TW'(fd_cnt - fd0), '0);
            return;
        end

        chk("done_pulse", TW'(frame_done), TW'(1));
        @(negedge clk); #1;
        chk("taps_valid_count", TW'(tv_cnt), TW'((ni - K + 1) * ni));
        chk("win_valid_count", TW'(win_cnt), TW'((ni - K + 1) * (ni - K + 1)));
        chk("frame_done_count", TW'(fd_cnt - fd0), TW'(1));
        chk("queue_drained", TW'(exp_q.size()), '0);
`ifdef CONV_TAPS_STALL_CNT_EN
        chk("stall_cnt", TW'(stall_cnt), TW'(idle));
`endif
        exp_q.delete();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_taps", taps, '0);
        chk("rst_taps_valid", TW'(taps_valid), '0);
        chk("rst_win_valid", TW'(win_valid), '0);
        chk("rst_busy", TW'(busy), '0);
        chk("rst_din_ready", TW'(din_ready), '0);
        chk("rst_frame_done", TW'(frame_done), '0);

        // layer 1 ramp, no gaps
        run_frame(1'b0, 0, 1'b0, 1'b0, 1'b0, -1);
        chk("l1_first_col", first_taps, col5(0, 28, 56, 84, 112));
        chk("l1_last_col", last_taps, col5(671, 699, 727, 755, 783));
        chk("l1_tv_672", TW'(tv_cnt), TW'(672));
        chk("l1_win_576", TW'(win_cnt), TW'(576));

        // layer 2 ramp with the layer select wiggling mid-frame
        run_frame(1'b1, 0, 1'b0, 1'b1, 1'b0, -1);
        chk("l2_first_col", first_taps, col5(0, 12, 24, 36, 48));
        chk("l2_tv_96", TW'(tv_cnt), TW'(96));
        chk("l2_win_64", TW'(win_cnt), TW'(64));

        // layer 1 ramp and random data with ~40% idle cycles
        run_frame(1'b0, 40, 1'b0, 1'b0, 1'b0, -1);
        chk("gap_last_col", last_taps, col5(671, 699, 727, 755, 783));
        run_frame(1'b0, 40, 1'b1, 1'b1, 1'b0, -1);

        // spurious start pulses while running
        run_frame(1'b0, 20, 1'b1, 1'b0, 1'b1, -1);

        // reset at pixel (10,5), then a fresh frame
        run_frame(1'b0, 0, 1'b1, 1'b0, 1'b0, 10 * NI_L1 + 5);
        run_frame(1'b0, 10, 1'b1, 1'b0, 1'b0, -1);

        // back-to-back layer 1 then layer 2
        run_frame(1'b0, 0, 1'b1, 1'b0, 1'b0, -1);
        run_frame(1'b1, 30, 1'b1, 1'b0, 1'b1, -1);

        repeat (4) @(posedge clk);
        #1;
        chk("end_idle_busy", TW'(busy), '0);
        chk("end_no_extra_columns", TW'(tv_cnt), TW'(96));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_taps_gen.md
Name: conv_taps_gen

Overview:
- Streaming line-buffer window generator that produces the 5-row pixel column feeding the binary 5x5 convolution engine.
- Accepts a raster-order pixel stream for one square feature map:
  - 28x28 for layer 1.
  - 12x12 for layer 2.
- Buffers the previous K-1 rows.
- Emits one aligned K-pixel column per accepted pixel, with valid and window-complete qualifiers.
- Sits between the feature-map memory reader and the convolution engine.

Parameters:
- K, 5, kernel height/width; number of rows per output column.
- DW, 32, signed pixel width.
- NI_L1, 28, feature-map width/height when state=0.
- NI_L2, 12, feature-map width/height when state=1.
- NI_MAX, 28, line-buffer physical depth; must be >= NI_L1 and >= NI_L2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a frame; layer select is sampled on this pulse.
- state  in  1  layer select: 0 = layer 1 (Ni=NI_L1), 1 = layer 2 (Ni=NI_L2).
- din  in  DW  pixel, raster order.
- din_valid  in  1  pixel present.
- din_ready  out  1  block accepts a pixel this cycle; a pixel transfers when din_valid && din_ready.
- taps  out  K*DW  column output. Bits [K*DW-1 -: DW] hold the oldest row (r-4); bits [DW-1:0] hold the current row r.
- taps_valid  out  1  taps carries a complete K-row column (row >= K-1).
- win_valid  out  1  taps_valid && col >= K-1: the downstream KxK window is complete at this column.
- busy  out  1  high while a frame is in progress.
- frame_done  out  1  one-cycle pulse after the final pixel's column is output.

Behaviour:
- FSM states: IDLE, RUN, DONE.
  - IDLE: din_ready=0. On start, latch state into layer_q, clear row/col, go to RUN.
  - RUN: din_ready=1. Each accepted pixel:
    - Pushes din into line buffer 0.
    - Each line buffer j pushes its Ni-delayed output into line buffer j+1.
    - col increments; it wraps at Ni-1 to 0 and increments row.
    - When the accepted pixel has row=Ni-1 and col=Ni-1, go to DONE.
  - DONE: frame_done=1 for exactly one cycle, then IDLE.
- Ni is derived from layer_q only. A change on state during RUN has no effect.
- start is ignored outside IDLE.
- Line buffer j (j=0..K-2):
  - Shift register of NI_MAX entries; advances only on an accepted pixel.
  - Read tap is at index Ni-1, so its output equals the pixel exactly Ni accepted pixels earlier.
- Latency: one register stage. taps, taps_valid, win_valid and the row/col qualifiers update on the cycle after acceptance.
- With no acceptance in a cycle:
  - taps holds its value.
  - taps_valid=0 and win_valid=0 for that cycle.
- taps = {lb3_out, lb2_out, lb1_out, lb0_out, din}, registered.
- Rows 0..K-2 fill the buffers only: taps_valid stays low for them.
- Output counts per frame:
  - taps_valid pulses: (Ni-K+1)*Ni.
  - win_valid pulses: (Ni-K+1)^2.
- Data is passed unmodified; there is no arithmetic on pixels. Counters are 5 bits.
- Reset:
  - Outputs: din_ready=0, taps=0, taps_valid=0, win_valid=0, busy=0, frame_done=0.
  - FSM goes to IDLE; row, col and layer_q clear.
  - Line-buffer storage is not reset. Stale data is never qualified, because taps_valid requires K-1 fresh rows.
- Reset mid-frame aborts the frame with no frame_done.
- busy = (FSM != IDLE).

Optional Feature:
- Macro: CONV_TAPS_STALL_CNT_EN.
- When defined:
  - Adds output port stall_cnt, 16 bits.
  - Counts RUN cycles with din_valid=0.
  - Clears on start and on rst; saturates at 16'hFFFF.
  - Holds its value after frame_done.
- When undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package conv_pkg holds:
  - K, DW, NI_L1, NI_L2, NI_MAX.
  - FSM state enum (IDLE/RUN/DONE).
  - Layer-select encoding.
- Sub-module lb_line: one variable-tap shift line.
  - Parameters: DW, NI_MAX.
  - Ports: clk, en, din, ni, dout.
  - Instantiated K-1 times.

Test Plan:
- Layer 1, pixel value = r*28+c, din_valid always 1:
  - First taps_valid appears after pixel (4,0), with taps = {0, 28, 56, 84, 112}.
  - Exactly 672 taps_valid pulses and 576 win_valid pulses.
  - Last column = {671, 699, 727, 755, 783}.
  - frame_done pulses once.
- Layer 2 (state=1), pixel value = r*12+c:
  - First valid column = {0, 12, 24, 36, 48}.
  - 96 taps_valid pulses, 64 win_valid pulses.
  - state toggled mid-frame has no effect.
- Random din_valid gaps (~40% idle) on layer 1:
  - The qualified taps sequence matches the gap-free run bit-for-bit.
  - No taps_valid on idle cycles.
  - stall_cnt equals the number of idle cycles (macro defined).
- start pulsed during RUN: ignored; counts and frame_done timing are unchanged.
- rst asserted at pixel (10,5) of layer 1:
  - All outputs are 0 the next cycle; no frame_done.
  - A fresh start frame produces the exact expected columns, with no stale data qualified.
- Back-to-back frames, layer 1 then layer 2, start issued the cycle after frame_done: both frames are correct with no bleed-through.
